// File: rtl/mem_stage.sv
// Memory stage of the 5-stage MIPS pipeline: data-cache request/stall control,
// LL/SC link register with coherence invalidation, and the MEM/WB pipeline register.
module mem_stage #(
   parameter int DATA_W  = 32,
   parameter bit LINK_EN = 1'b1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              flush_i,
   input  logic [DATA_W-1:0] aluout_i,
   input  logic [DATA_W-1:0] rdat2_i,
   input  logic [DATA_W-1:0] npc_i,
   input  logic [4:0]        wsel_i,
   input  logic              rfWEN_i,
   input  logic [1:0]        rfInSel_i,
   input  logic              dREN_i,
   input  logic              dWEN_i,
   input  logic              ll_i,
   input  logic              sc_i,
   input  logic              halt_i,
   input  logic              dhit,
   input  logic [DATA_W-1:0] dmemload,
   input  logic              ccinv,
   input  logic [DATA_W-1:0] ccsnoopaddr,
   output logic              dmemREN,
   output logic              dmemWEN,
   output logic [DATA_W-1:0] dmemaddr,
   output logic [DATA_W-1:0] dmemstore,
   output logic              mem_stall,
   output logic [DATA_W-1:0] wb_wdat_o,
   output logic [4:0]        wb_wsel_o,
   output logic              wb_rfWEN_o,
   output logic              wb_halt_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t state, state_next;

   logic              link_valid;
   logic [DATA_W-1:0] link_addr;

   logic              addr_match;
   logic              snoop_link;
   logic              snoop_new;
   logic              scfail;
   logic              req;
   logic              ll_done;
   logic              sc_done;
   logic              store_hit;
   logic              inv;
   logic              wb_load;
   logic [DATA_W-1:0] wdat_mux;

   // Word-granular compares: the byte offset never distinguishes a linked location.
   assign addr_match = link_addr[DATA_W-1:2] == aluout_i[DATA_W-1:2];
   assign snoop_link = ccsnoopaddr[DATA_W-1:2] == link_addr[DATA_W-1:2];
   assign snoop_new  = ccsnoopaddr[DATA_W-1:2] == aluout_i[DATA_W-1:2];

   assign scfail    = sc_i & ~(link_valid & addr_match);
   assign req       = (dREN_i | dWEN_i) & ~scfail & (state != HALTED);
   assign dmemREN   = req & dREN_i;
   assign dmemWEN   = req & dWEN_i;
   assign dmemaddr  = aluout_i;
   assign dmemstore = rdat2_i;
   assign mem_stall = req & ~dhit;

   assign ll_done   = req & dREN_i & ll_i & dhit;
   assign sc_done   = sc_i & (scfail | (req & dhit));
   assign store_hit = req & dWEN_i & dhit & addr_match;
   // A snoop racing an LL completion is compared against the address being linked.
   assign inv       = ccinv & (ll_done ? snoop_new : snoop_link);
   assign wb_load   = ~mem_stall & ~flush_i & (state != HALTED);

   always_comb begin
      wdat_mux = aluout_i;
      if (sc_i)
         wdat_mux = {{(DATA_W-1){1'b0}}, ~scfail};
      else if (rfInSel_i == 2'd1)
         wdat_mux = dmemload;
      else if (rfInSel_i == 2'd2)
         wdat_mux = npc_i;
   end

   always_comb begin
      state_next = state;
      if (state != HALTED && halt_i && wb_load)
         state_next = HALTED;
      else if (state == IDLE && req && !dhit)
         state_next = WAIT;
      else if (state == WAIT && dhit)
         state_next = IDLE;
   end

   always_ff @(posedge CLK) begin
      if (RST)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         link_valid <= 1'b0;
         link_addr  <= '0;
      end else begin
         if (inv || sc_done || store_hit)
            link_valid <= 1'b0;
         else if (ll_done)
            link_valid <= LINK_EN;
         if (ll_done)
            link_addr <= aluout_i;
      end
   end

   // Stall, flush and halt all write a bubble; wb_halt_o only ever clears on reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wb_wdat_o  <= '0;
         wb_wsel_o  <= '0;
         wb_rfWEN_o <= 1'b0;
         wb_halt_o  <= 1'b0;
      end else if (wb_load) begin
         wb_wdat_o  <= wdat_mux;
         wb_wsel_o  <= wsel_i;
         wb_rfWEN_o <= rfWEN_i;
         wb_halt_o  <= wb_halt_o | halt_i;
      end else begin
         wb_wdat_o  <= '0;
         wb_wsel_o  <= '0;
         wb_rfWEN_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: cache handshake, LL/SC link, MEM/WB, halt and reset.
module tb_mem_stage;

   logic        CLK = 1'b0;
   logic        RST;
   logic        flush_i;
   logic [31:0] aluout_i;
   logic [31:0] rdat2_i;
   logic [31:0] npc_i;
   logic [4:0]  wsel_i;
   logic        rfWEN_i;
   logic [1:0]  rfInSel_i;
   logic        dREN_i;
   logic        dWEN_i;
   logic        ll_i;
   logic        sc_i;
   logic        halt_i;
   logic        dhit;
   logic [31:0] dmemload;
   logic        ccinv;
   logic [31:0] ccsnoopaddr;
   logic        dmemREN;
   logic        dmemWEN;
   logic [31:0] dmemaddr;
   logic [31:0] dmemstore;
   logic        mem_stall;
   logic [31:0] wb_wdat_o;
   logic [4:0]  wb_wsel_o;
   logic        wb_rfWEN_o;
   logic        wb_halt_o;

   int testsRun = 0;
   int testsFailed = 0;
   int stallCount;

   mem_stage #(.DATA_W(32), .LINK_EN(1'b1)) dut (
      .CLK(CLK), .RST(RST), .flush_i(flush_i),
      .aluout_i(aluout_i), .rdat2_i(rdat2_i), .npc_i(npc_i),
      .wsel_i(wsel_i), .rfWEN_i(rfWEN_i), .rfInSel_i(rfInSel_i),
      .dREN_i(dREN_i), .dWEN_i(dWEN_i), .ll_i(ll_i), .sc_i(sc_i),
      .halt_i(halt_i), .dhit(dhit), .dmemload(dmemload),
      .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
      .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
      .dmemstore(dmemstore), .mem_stall(mem_stall),
      .wb_wdat_o(wb_wdat_o), .wb_wsel_o(wb_wsel_o),
      .wb_rfWEN_o(wb_rfWEN_o), .wb_halt_o(wb_halt_o)
   );

   always #5 CLK = ~CLK;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected)
      else begin
         testsFailed++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkFlag(input string tag, input logic observed, input logic expected);
      testsRun++;
      assert (observed === expected)
      else begin
         testsFailed++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clearInputs();
      flush_i = 0; aluout_i = 0; rdat2_i = 0; npc_i = 0; wsel_i = 0;
      rfWEN_i = 0; rfInSel_i = 0; dREN_i = 0; dWEN_i = 0; ll_i = 0; sc_i = 0;
      halt_i = 0; dhit = 0; dmemload = 0; ccinv = 0; ccsnoopaddr = 0;
   endtask

   task automatic applyStimulus(input logic ren, input logic wen, input logic ll, input logic sc,
                                input logic [31:0] addr, input logic [31:0] st, input logic [1:0] sel,
                                input logic [4:0] ws, input logic wr);
      dREN_i = ren; dWEN_i = wen; ll_i = ll; sc_i = sc;
      aluout_i = addr; rdat2_i = st; rfInSel_i = sel; wsel_i = ws; rfWEN_i = wr;
      #1;
   endtask

   initial begin
      clearInputs();
      RST = 1'b1;
      tick();
      tick();
      RST = 1'b0;
      checkOutput("reset_wdat", wb_wdat_o, 32'h0);
      checkFlag("reset_rfwen", wb_rfWEN_o, 1'b0);
      checkFlag("reset_halt", wb_halt_o, 1'b0);
      checkFlag("reset_stall", mem_stall, 1'b0);

      // Load hitting in its first cycle
      dhit = 1; dmemload = 32'hDEADBEEF;
      applyStimulus(1, 0, 0, 0, 32'h40, 32'h0, 2'd1, 5'd8, 1);
      checkFlag("load_ren", dmemREN, 1'b1);
      checkFlag("load_nostall", mem_stall, 1'b0);
      checkOutput("load_addr", dmemaddr, 32'h40);
      tick();
      checkOutput("load_wdat", wb_wdat_o, 32'hDEADBEEF);
      checkOutput("load_wsel", {27'b0, wb_wsel_o}, 32'd8);
      checkFlag("load_rfwen", wb_rfWEN_o, 1'b1);

      // Store with a three-cycle miss
      clearInputs();
      applyStimulus(0, 1, 0, 0, 32'h80, 32'h1234, 2'd0, 5'd0, 0);
      stallCount = 0;
      for (int i = 0; i < 3; i++) begin
         checkFlag("store_wen_miss", dmemWEN, 1'b1);
         checkOutput("store_data", dmemstore, 32'h1234);
         if (mem_stall) stallCount++;
         tick();
         checkFlag("store_bubble", wb_rfWEN_o, 1'b0);
      end
      dhit = 1; #1;
      checkFlag("store_wen_hit", dmemWEN, 1'b1);
      if (mem_stall) stallCount++;
      checkOutput("store_stall_cycles", stallCount, 32'd3);
      tick();
      checkFlag("store_rfwen", wb_rfWEN_o, 1'b0);

      // LL then successful SC; the link is consumed
      clearInputs(); dhit = 1; dmemload = 32'h77;
      applyStimulus(1, 0, 1, 0, 32'h100, 32'h0, 2'd1, 5'd9, 1);
      tick();
      checkOutput("ll_wdat", wb_wdat_o, 32'h77);
      applyStimulus(0, 1, 0, 1, 32'h100, 32'd5, 2'd0, 5'd10, 1);
      checkFlag("sc_ok_wen", dmemWEN, 1'b1);
      checkOutput("sc_ok_store", dmemstore, 32'd5);
      checkFlag("sc_ok_nostall", mem_stall, 1'b0);
      tick();
      checkOutput("sc_ok_wdat", wb_wdat_o, 32'd1);
      dhit = 0;
      applyStimulus(0, 1, 0, 1, 32'h100, 32'd5, 2'd0, 5'd10, 1);
      checkFlag("sc_relink_wen", dmemWEN, 1'b0);
      checkFlag("sc_relink_stall", mem_stall, 1'b0);
      tick();
      checkOutput("sc_relink_wdat", wb_wdat_o, 32'd0);
      checkFlag("sc_relink_rfwen", wb_rfWEN_o, 1'b1);

      // LL, matching invalidate, then SC fails
      clearInputs(); dhit = 1;
      applyStimulus(1, 0, 1, 0, 32'h100, 32'h0, 2'd1, 5'd9, 1);
      tick();
      clearInputs(); ccinv = 1; ccsnoopaddr = 32'h100;
      tick();
      clearInputs();
      applyStimulus(0, 1, 0, 1, 32'h100, 32'd5, 2'd0, 5'd10, 1);
      checkFlag("inv_sc_wen", dmemWEN, 1'b0);
      checkFlag("inv_sc_stall", mem_stall, 1'b0);
      tick();
      checkOutput("inv_sc_wdat", wb_wdat_o, 32'd0);

      // A non-matching invalidate leaves the link intact
      clearInputs(); dhit = 1;
      applyStimulus(1, 0, 1, 0, 32'h200, 32'h0, 2'd1, 5'd9, 1);
      tick();
      clearInputs(); ccinv = 1; ccsnoopaddr = 32'h300;
      tick();
      clearInputs(); dhit = 1;
      applyStimulus(0, 1, 0, 1, 32'h202, 32'd6, 2'd0, 5'd10, 1);
      checkFlag("nomatch_sc_wen", dmemWEN, 1'b1);
      tick();
      checkOutput("nomatch_sc_wdat", wb_wdat_o, 32'd1);

      // LL completion racing a matching invalidate
      clearInputs(); dhit = 1; ccinv = 1; ccsnoopaddr = 32'h100;
      applyStimulus(1, 0, 1, 0, 32'h100, 32'h0, 2'd1, 5'd9, 1);
      tick();
      clearInputs(); dhit = 1;
      applyStimulus(0, 1, 0, 1, 32'h100, 32'd5, 2'd0, 5'd10, 1);
      checkFlag("race_sc_wen", dmemWEN, 1'b0);
      tick();
      checkOutput("race_sc_wdat", wb_wdat_o, 32'd0);

      // A plain store to the linked word breaks the link
      clearInputs(); dhit = 1;
      applyStimulus(1, 0, 1, 0, 32'h180, 32'h0, 2'd1, 5'd9, 1);
      tick();
      applyStimulus(0, 1, 0, 0, 32'h180, 32'h9, 2'd0, 5'd0, 0);
      tick();
      applyStimulus(0, 1, 0, 1, 32'h180, 32'd5, 2'd0, 5'd10, 1);
      checkFlag("storebrk_sc_wen", dmemWEN, 1'b0);
      tick();

      // Writeback source mux: NPC and the reserved encoding
      clearInputs(); npc_i = 32'h404;
      applyStimulus(0, 0, 0, 0, 32'h99, 32'h0, 2'd2, 5'd31, 1);
      tick();
      checkOutput("npc_wdat", wb_wdat_o, 32'h404);
      applyStimulus(0, 0, 0, 0, 32'h99, 32'h0, 2'd3, 5'd31, 1);
      tick();
      checkOutput("rsv_wdat", wb_wdat_o, 32'h99);

      // Flush clears the register
      flush_i = 1;
      tick();
      checkFlag("flush_rfwen", wb_rfWEN_o, 1'b0);
      checkOutput("flush_wdat", wb_wdat_o, 32'h0);

      // Reset while waiting on a miss, with a live link
      clearInputs(); dhit = 1;
      applyStimulus(1, 0, 1, 0, 32'h100, 32'h0, 2'd1, 5'd9, 1);
      tick();
      dhit = 0;
      applyStimulus(1, 0, 0, 0, 32'h140, 32'h0, 2'd1, 5'd4, 1);
      checkFlag("wait_stall", mem_stall, 1'b1);
      tick();
      clearInputs(); RST = 1;
      tick();
      RST = 0;
      checkOutput("rstwait_wdat", wb_wdat_o, 32'h0);
      checkFlag("rstwait_rfwen", wb_rfWEN_o, 1'b0);
      checkFlag("rstwait_stall", mem_stall, 1'b0);
      dhit = 1;
      applyStimulus(0, 1, 0, 1, 32'h100, 32'd5, 2'd0, 5'd10, 1);
      checkFlag("rstwait_link", dmemWEN, 1'b0);
      tick();

      // Halt is sticky against later requests and flushes
      clearInputs(); halt_i = 1;
      tick();
      checkFlag("halt_set", wb_halt_o, 1'b1);
      clearInputs();
      applyStimulus(1, 0, 0, 0, 32'h40, 32'h0, 2'd1, 5'd8, 1);
      checkFlag("halt_noren", dmemREN, 1'b0);
      checkFlag("halt_nostall", mem_stall, 1'b0);
      tick();
      checkFlag("halt_hold", wb_halt_o, 1'b1);
      clearInputs(); flush_i = 1;
      tick();
      checkFlag("halt_flush", wb_halt_o, 1'b1);
      clearInputs(); RST = 1;
      tick();
      RST = 0;
      checkFlag("halt_reset", wb_halt_o, 1'b0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
